// File: rtl/temporal_pkg.sv
// Shared definitions for the temporal-logic pipeline: encoder FSM states and
// the tick/value width derivation used by every stage.
package temporal_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } encoder_state_t;

  function automatic int val_width(input int gamma_cycle_width);
    return (gamma_cycle_width <= 2) ? 1 : $clog2(gamma_cycle_width);
  endfunction

endpackage

// File: rtl/pulse_window_cmp.sv
// One channel of the spike window: high when tick lies in [val+1, val+PULSE_WIDTH].
module pulse_window_cmp #(
  parameter int VAL_W       = 4,
  parameter int PULSE_WIDTH = 8
) (
  input  logic [VAL_W-1:0] tick_i,
  input  logic [VAL_W-1:0] val_i,
  input  logic             mask_i,
  output logic             hit_o
);

  // One extra bit so val+PULSE_WIDTH never wraps back into the window.
  logic [VAL_W:0] tick_ext;
  logic [VAL_W:0] lo;
  logic [VAL_W:0] hi;

  assign tick_ext = {1'b0, tick_i};
  assign lo       = {1'b0, val_i} + (VAL_W+1)'(1);
  assign hi       = {1'b0, val_i} + (VAL_W+1)'(PULSE_WIDTH);
  assign hit_o    = mask_i && (tick_ext >= lo) && (tick_ext <= hi);

endmodule

// File: rtl/temporal_pulse_encoder.sv
// Converts per-channel spike times into temporal pulses framed by gamma cycles,
// with a one-deep shadow so consecutive value sets run back to back.
module temporal_pulse_encoder
  import temporal_pkg::*;
#(
  parameter  int GAMMA_CYCLE_WIDTH = 16,
  parameter  int PULSE_WIDTH       = 8,
  parameter  int N_CH              = 2,
  localparam int VAL_W             = val_width(GAMMA_CYCLE_WIDTH)
) (
  input  logic                  aclk,
  input  logic                  grst_n,
  input  logic                  clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_CH*VAL_W-1:0] in_val,
  input  logic [N_CH-1:0]       in_mask,
  output logic [N_CH-1:0]       pulse,
  output logic                  gamma_rst,
  output logic [VAL_W-1:0]      tick,
  output logic                  busy,
  output encoder_state_t        dbg_state
);

  localparam logic [VAL_W-1:0] LAST_TICK = VAL_W'(GAMMA_CYCLE_WIDTH - 1);

  encoder_state_t        state_q, state_d;
  logic [VAL_W-1:0]      tick_q, tick_d;
  logic                  gamma_rst_q, gamma_rst_d;
  logic                  busy_q;
  logic [N_CH-1:0]       pulse_q, pulse_d, hit;
  logic [N_CH*VAL_W-1:0] sh_val_q, sh_val_d, act_val_q, act_val_d;
  logic [N_CH-1:0]       sh_mask_q, sh_mask_d, act_mask_q, act_mask_d;
  logic                  sh_full_q, sh_full_d;
  logic                  accept;

  // Handshake: a set transfers on a cycle where in_valid && in_ready; in_ready
  // depends only on shadow occupancy and clr, never on in_valid.
  assign in_ready = ~sh_full_q & ~clr;
  assign accept   = in_valid & in_ready;

  always_comb begin
    state_d     = state_q;
    tick_d      = tick_q;
    gamma_rst_d = 1'b0;
    sh_val_d    = sh_val_q;
    sh_mask_d   = sh_mask_q;
    sh_full_d   = sh_full_q;
    act_val_d   = act_val_q;
    act_mask_d  = act_mask_q;
    if (clr) begin
      state_d    = IDLE;
      tick_d     = '0;
      sh_val_d   = '0;
      sh_mask_d  = '0;
      sh_full_d  = 1'b0;
      act_val_d  = '0;
      act_mask_d = '0;
    end else begin
      if (accept) begin
        sh_val_d  = in_val;
        sh_mask_d = in_mask;
        sh_full_d = 1'b1;
      end
      // A frame boundary (IDLE or last tick) promotes the shadow, or bypasses
      // it when the set arrives in that very cycle.
      if (state_q == IDLE || tick_q == LAST_TICK) begin
        tick_d = '0;
        if (sh_full_q) begin
          act_val_d   = sh_val_q;
          act_mask_d  = sh_mask_q;
          sh_full_d   = 1'b0;
          state_d     = RUN;
          gamma_rst_d = 1'b1;
        end else if (accept) begin
          act_val_d   = in_val;
          act_mask_d  = in_mask;
          sh_full_d   = 1'b0;
          state_d     = RUN;
          gamma_rst_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_window_cmp #(
      .VAL_W      (VAL_W),
      .PULSE_WIDTH(PULSE_WIDTH)
    ) u_cmp (
      .tick_i(tick_d),
      .val_i (act_val_d[i*VAL_W +: VAL_W]),
      .mask_i(act_mask_d[i]),
      .hit_o (hit[i])
    );
  end

  assign pulse_d = hit & {N_CH{state_d == RUN}};

  always_ff @(posedge aclk or negedge grst_n) begin
    if (!grst_n) begin
      state_q     <= IDLE;
      tick_q      <= '0;
      gamma_rst_q <= 1'b0;
      busy_q      <= 1'b0;
      pulse_q     <= '0;
      sh_val_q    <= '0;
      sh_mask_q   <= '0;
      sh_full_q   <= 1'b0;
      act_val_q   <= '0;
      act_mask_q  <= '0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      gamma_rst_q <= gamma_rst_d;
      busy_q      <= (state_d == RUN);
      pulse_q     <= pulse_d;
      sh_val_q    <= sh_val_d;
      sh_mask_q   <= sh_mask_d;
      sh_full_q   <= sh_full_d;
      act_val_q   <= act_val_d;
      act_mask_q  <= act_mask_d;
    end
  end

  assign pulse     = pulse_q;
  assign gamma_rst = gamma_rst_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule
